mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the 16-bit RISC processor. It answers the controller's `mem_rd`/`mem_wr` strobes: it selects the PC or the data address, applies a programmable number of wait states, performs one access to a 256x16 single-port memory, and returns read data with a one-cycle `ready` pulse. It sits between the controller/datapath and storage, serving both instruction fetch and LD/SW data accesses.

## Interface
Parameters:
- `WAIT_CYCLES`, default 0: extra wait states per access, legal range 0..15.
- `DATA_W`, default 16: word width.
- `ADDR_W`, default 8: address width, which gives a depth of 2^ADDR_W = 256 words.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `mem_rd`  in  1  read request level from the controller.
- `mem_wr`  in  1  write request level from the controller.
- `mem_addr_sel`  in  1  selects the address source: 0 = `pc`, 1 = `d_addr`.
- `pc`  in  ADDR_W  program counter address.
- `d_addr`  in  ADDR_W  data address (instr[7:0]).
- `wdata`  in  DATA_W  store data (register file Rp port).
- `rdata`  out  DATA_W  registered read data; holds its value until the next read completes.
- `ready`  out  1  one-cycle pulse marking access completion.
- `busy`  out  1  high while an access is in progress (BUSY state).
- `err`  out  1  one-cycle pulse when `mem_rd` and `mem_wr` are both high at request sampling.

## Operation
- FSM states are IDLE, BUSY and HOLD.
- IDLE:
  - Exactly one of `mem_rd`/`mem_wr` high at a clock edge starts a request.
  - At that edge the block captures the op, the address (`mem_addr_sel ? d_addr : pc`) and `wdata`.
  - It loads `wcnt = WAIT_CYCLES` and moves to BUSY.
  - Both `mem_rd` and `mem_wr` high: `err`=1 for the next cycle, no memory access, go to HOLD.
  - Neither high: stay in IDLE.
- BUSY:
  - While `wcnt != 0`, decrement it.
  - At the edge where `wcnt == 0`, perform the access:
    - read: `rdata` <= mem[addr];
    - write: mem[addr] <= captured `wdata`, and `rdata` is unchanged.
  - At the same edge set `ready`=1 and go to HOLD.
  - Input changes during BUSY are ignored, because all operands were captured at the request edge.
- HOLD:
  - `ready` and `err` return to 0 after their single cycle.
  - Stay in HOLD until `mem_rd`=0 and `mem_wr`=0 are sampled together, then go to IDLE.
  - This prevents a level-held strobe from being serviced twice.
- Memory array contents are not affected by `rst` and are undefined at power-up.
- Address arithmetic: none. Addresses are used as 8-bit indices; there is no wrap, since the full 256-word space is mapped.
- Reset values: state=IDLE, `rdata`=0, `ready`=0, `busy`=0, `err`=0, `wcnt`=0.
- Reset mid-access: the FSM returns to IDLE, and a pending write that has not yet committed is dropped (memory unchanged).

## Timing
- Request first high in cycle N and sampled at the end of N.
- BUSY occupies cycles N+1 .. N+1+WAIT_CYCLES.
- `ready` and valid `rdata` appear in cycle N+2+WAIT_CYCLES, giving a latency of WAIT_CYCLES+2 cycles.
- A write is visible to a read that issues its request in the cycle after `ready`.
- `busy` is a registered state decode: high exactly in the BUSY cycles.
- Minimum spacing between two accesses: requests must deassert for at least one sampled edge in HOLD. A re-request can therefore be sampled in IDLE no earlier than two cycles after `ready`.
- `err` is high in cycle N+1 for an illegal request; `ready` does not assert.
- `rst` dominates every other event on the same edge.

## Structure
- Shared package `risc_pkg` holds:
  - the state enum (IDLE, BUSY, HOLD);
  - constants `DATA_W`=16, `ADDR_W`=8, `MEM_DEPTH`=256;
  - the op encoding (RD, WR).
- One sub-module, `mem_array`: a single-port synchronous 256x16 RAM with write enable and a registered read, instantiated once.
- The FSM, wait counter and operand capture registers live in `mem_responder`.

## Test plan
- Reset: assert `rst` for 2 cycles mid-BUSY of a write of 0xBEEF to address 0x10. Required: all outputs 0; a later read of 0x10 does not return 0xBEEF if the location was previously written with 0x1234 (returns 0x1234).
- Write/read, WAIT_CYCLES=0:
  - write 0xA5C3 to `d_addr`=0x20 (`mem_addr_sel`=1) in cycle N, giving `ready` in N+2;
  - drop the strobe, then read 0x20, giving `rdata`=0xA5C3 with `ready` 2 cycles after the request.
- Wait states, WAIT_CYCLES=3: fetch from `pc`=0x00 preloaded with 0x0123. Required: `busy` high for 4 cycles, `ready` in N+5, `rdata`=0x0123.
- Level-held strobe: hold `mem_rd` high for 8 cycles. Required: exactly one `ready` pulse; a second access starts only after the strobe drops.
- Operand capture: change `d_addr` from 0x30 to 0x31 and `wdata` during BUSY. Required: the write lands at 0x30 with the original data, and 0x31 is untouched.
- Illegal request: `mem_rd`=`mem_wr`=1 with address 0x40 holding 0x7777. Required: `err` pulse in N+1, no `ready`, 0x40 still 0x7777, `rdata` unchanged.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg: shared types and constants for the 16-bit RISC memory side.
// Holds the responder FSM state encoding, the access op encoding and the memory geometry.
`default_nettype none

package risc_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 8;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

`default_nettype wire

// File: rtl/mem_responder_if.sv
// mem_responder_if: controller <-> memory responder request/response bundle.
// The master side issues strobes and operands; the slave side returns data and status.
`default_nettype none

interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);

  logic              mem_rd;
  logic              mem_wr;
  logic              mem_addr_sel;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;
  logic              err;

  modport master (
    output mem_rd, mem_wr, mem_addr_sel, pc, d_addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  mem_rd, mem_wr, mem_addr_sel, pc, d_addr, wdata,
    output rdata, ready, busy, err
  );

endinterface

`default_nettype wire

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM with write enable and a registered read port.
// Only the read register is reset; the storage array keeps its contents across rst.
`default_nettype none

module mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read data holds between reads so a write never disturbs the last fetched word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// mem_responder: answers mem_rd/mem_wr strobes with one wait-stated RAM access and a ready pulse.
// Operands are captured at the request edge; HOLD waits for the strobes to drop before re-arming.
`default_nettype none

module mem_responder #(
  parameter int WAIT_CYCLES = 0,
  parameter int DATA_W      = risc_pkg::DATA_W,
  parameter int ADDR_W      = risc_pkg::ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  import risc_pkg::*;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e            state;
  logic [3:0]        wcnt;
  op_e               op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata_cap;
  logic              ready_pulse;
  logic              err_pulse;
  logic              busy_flag;
  logic              access_now;

  // Gating with rst drops a write that has not committed when reset lands on its edge.
  assign access_now = (state == BUSY) && (wcnt == 4'd0) && !rst;

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk   (clk),
    .rst   (rst),
    .en    (access_now),
    .we    (op == OP_WR),
    .addr  (addr),
    .wdata (wdata_cap),
    .rdata (bus.rdata)
  );

  assign bus.ready = ready_pulse;
  assign bus.err   = err_pulse;
  assign bus.busy  = busy_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wcnt        <= 4'd0;
      op          <= OP_RD;
      addr        <= '0;
      wdata_cap   <= '0;
      ready_pulse <= 1'b0;
      err_pulse   <= 1'b0;
      busy_flag   <= 1'b0;
    end else begin
      ready_pulse <= 1'b0;
      err_pulse   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_rd && bus.mem_wr) begin
            err_pulse <= 1'b1;
            state     <= HOLD;
          end else if (bus.mem_rd || bus.mem_wr) begin
            op        <= bus.mem_wr ? OP_WR : OP_RD;
            addr      <= bus.mem_addr_sel ? bus.d_addr : bus.pc;
            wdata_cap <= bus.wdata;
            wcnt      <= WAIT_INIT;
            busy_flag <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
          end else begin
            ready_pulse <= 1'b1;
            busy_flag   <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (!bus.mem_rd && !bus.mem_wr) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for two responders (WAIT_CYCLES 0 and 3).
`default_nettype none

module tb_mem_responder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_responder_if #(.DATA_W(16), .ADDR_W(8)) bus0 ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(8)) bus3 ();

  mem_responder #(.WAIT_CYCLES(0), .DATA_W(16), .ADDR_W(8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  mem_responder #(.WAIT_CYCLES(3), .DATA_W(16), .ADDR_W(8)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w3, input logic rd, input logic wr, input logic sel,
                       input logic [7:0] pcv, input logic [7:0] da, input logic [15:0] wd);
    if (w3) begin
      bus3.mem_rd = rd; bus3.mem_wr = wr; bus3.mem_addr_sel = sel;
      bus3.pc = pcv; bus3.d_addr = da; bus3.wdata = wd;
    end else begin
      bus0.mem_rd = rd; bus0.mem_wr = wr; bus0.mem_addr_sel = sel;
      bus0.pc = pcv; bus0.d_addr = da; bus0.wdata = wd;
    end
  endtask

  task automatic drop(input bit w3);
    if (w3) begin
      bus3.mem_rd = 1'b0; bus3.mem_wr = 1'b0;
    end else begin
      bus0.mem_rd = 1'b0; bus0.mem_wr = 1'b0;
    end
  endtask

  function automatic logic ready_of(input bit w3);
    return w3 ? bus3.ready : bus0.ready;
  endfunction

  function automatic logic busy_of(input bit w3);
    return w3 ? bus3.busy : bus0.busy;
  endfunction

  function automatic logic [15:0] rdata_of(input bit w3);
    return w3 ? bus3.rdata : bus0.rdata;
  endfunction

  // Wait (bounded) for ready; latency counts edges from the request cycle.
  task automatic wait_ready(input bit w3, input string tag, input int exp_lat, input int exp_busy);
    int  lat;
    int  bc;
    bit  got;
    lat = 0; bc = 0; got = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      tick();
      if (busy_of(w3)) bc++;
      if (ready_of(w3)) begin
        got = 1'b1;
        lat = i;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, bc, exp_busy);
    drop(w3);
    tick();
  endtask

  task automatic access(input bit w3, input logic rd, input logic wr, input logic sel,
                        input logic [7:0] pcv, input logic [7:0] da, input logic [15:0] wd,
                        input string tag);
    drive(w3, rd, wr, sel, pcv, da, wd);
    wait_ready(w3, tag, w3 ? 5 : 2, w3 ? 4 : 1);
  endtask

  initial begin
    int ready_cnt;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
    tick();
    tick();
    check("rst0_rdata", bus0.rdata, 16'h0000);
    check("rst0_flags", {bus0.ready, bus0.busy, bus0.err}, 3'b000);
    check("rst3_rdata", bus3.rdata, 16'h0000);
    check("rst3_flags", {bus3.ready, bus3.busy, bus3.err}, 3'b000);
    rst = 1'b0;
    tick();

    // Reset mid-BUSY of a write must drop it.
    access(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h10, 16'h1234, "wr_10");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h10, 16'hBEEF);
    tick();
    check("midbusy_busy", bus0.busy, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    check("rst_mid_rdata", bus0.rdata, 16'h0000);
    check("rst_mid_flags", {bus0.ready, bus0.busy, bus0.err}, 3'b000);
    rst = 1'b0;
    drop(1'b0);
    tick();
    access(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h10, 16'h0000, "rd_10");
    check("rd_10_data", bus0.rdata, 16'h1234);

    // Zero-wait write then read through d_addr.
    access(1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 8'h20, 16'hA5C3, "wr_20");
    check("wr_keeps_rdata", bus0.rdata, 16'h1234);
    access(1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 8'h20, 16'h0000, "rd_20");
    check("rd_20_data", bus0.rdata, 16'hA5C3);

    // Three wait states, address from pc.
    access(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h55, 16'h0123, "w3_wr_00");
    access(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h55, 16'h0000, "w3_fetch_00");
    check("w3_fetch_data", bus3.rdata, 16'h0123);

    // Level-held strobe is serviced once.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h10, 16'h0000);
    ready_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus0.ready) ready_cnt++;
    end
    check("held_ready_count", ready_cnt, 1);
    check("held_busy", bus0.busy, 1'b0);
    check("held_data", bus0.rdata, 16'h1234);
    drop(1'b0);
    tick();
    access(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h20, 16'h0000, "rerequest");
    check("rerequest_data", bus0.rdata, 16'hA5C3);

    // Operand capture: inputs changed during BUSY are ignored.
    access(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h31, 16'h5555, "w3_wr_31");
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h30, 16'hCAFE);
    tick();
    check("cap_busy", bus3.busy, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h31, 8'h31, 16'hDEAD);
    wait_ready(1'b1, "cap_wr", 4, 3);
    access(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h30, 16'h0000, "cap_rd_30");
    check("cap_30_data", bus3.rdata, 16'hCAFE);
    access(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h31, 16'h0000, "cap_rd_31");
    check("cap_31_data", bus3.rdata, 16'h5555);

    // Illegal request: err pulse, no access, no ready.
    access(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h40, 16'h7777, "wr_40");
    access(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h20, 16'h0000, "rd_20_again");
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h40, 16'h0000);
    tick();
    check("ill_n1_flags", {bus0.err, bus0.ready, bus0.busy}, 3'b100);
    tick();
    check("ill_n2_flags", {bus0.err, bus0.ready, bus0.busy}, 3'b000);
    tick();
    check("ill_n3_flags", {bus0.err, bus0.ready, bus0.busy}, 3'b000);
    drop(1'b0);
    tick();
    check("ill_rdata_kept", bus0.rdata, 16'hA5C3);
    access(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h40, 16'h0000, "rd_40");
    check("rd_40_data", bus0.rdata, 16'h7777);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
